// File: rtl/pipelined_decode_stage_if.sv
// ID/EX pipeline-register bundle between the decode stage (master) and the execute stage (slave).
interface pipelined_decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
);
  logic              idex_valid;
  logic [15:0]       idex_instr;
  logic [PC_W-1:0]   idex_pc;
  logic [DATA_W-1:0] idex_rs_data;
  logic [DATA_W-1:0] idex_rt_data;
  logic [DATA_W-1:0] idex_imm;
  logic [3:0]        idex_rd;
  logic              idex_wr_en;
  logic              idex_mem_rd;
  logic              idex_mem_wr;
  logic [2:0]        idex_flag_we;

  modport master (
    output idex_valid, idex_instr, idex_pc, idex_rs_data, idex_rt_data, idex_imm,
           idex_rd, idex_wr_en, idex_mem_rd, idex_mem_wr, idex_flag_we
  );
  modport slave (
    input  idex_valid, idex_instr, idex_pc, idex_rs_data, idex_rt_data, idex_imm,
           idex_rd, idex_wr_en, idex_mem_rd, idex_mem_wr, idex_flag_we
  );
endinterface

// File: rtl/pipelined_decode_stage.sv
// Decode stage: register file, N/Z/V flags, in-decode branch resolution, hazard
// detection with optional EX/MEM forwarding to the BR operand, and the ID/EX register.
module pipelined_decode_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [15:0]       instr_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              wb_we,
  input  logic [3:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        flag_we,
  input  logic [2:0]        flags_in,
  input  logic              exm_wr_en,
  input  logic [3:0]        exm_wr_reg,
  input  logic              exm_is_load,
  input  logic [DATA_W-1:0] exm_result,
  output logic              stall,
  output logic              flush,
  output logic [PC_W-1:0]   branch_pc,
  output logic              halted,
  pipelined_decode_stage_if.master idex
);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_AL3 = 4'h3,
    OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_AL7 = 4'h7,
    OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic              valid;
    logic [15:0]       instr;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [3:0]        rd;
    logic              wr_en;
    logic              mem_rd;
    logic              mem_wr;
    logic [2:0]        flag_we;
  } idex_t;

  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];
  logic [2:0]        flags_q, flags_d;
  logic              halted_q, halted_d;
  idex_t             idex_q, idex_d;

  opcode_e           op;
  logic [3:0]        rs_idx, rt_idx;
  logic              uses_rs, uses_rt, is_b, is_br, cond_true;
  logic [DATA_W-1:0] rs_val, rt_val, rs_op, imm;
  logic              fwd_hit;
  logic              haz_load, haz_br_idex, haz_br_exm, haz_flag;
  logic [PC_W-1:0]   pc_plus2, b_target;

  always_comb begin
    op      = opcode_e'(instr_in[15:12]);
    is_b    = (op == OP_B);
    is_br   = (op == OP_BR);
    rs_idx  = (op == OP_LLB || op == OP_LHB) ? instr_in[11:8] : instr_in[7:4];
    rt_idx  = (op == OP_LW  || op == OP_SW)  ? instr_in[11:8] : instr_in[3:0];
    uses_rs = (instr_in[15:12] <= 4'hB) || is_br;
    uses_rt = (instr_in[15] == 1'b0) || (op == OP_SW);

    // WB write in the same cycle wins over the stored value
    rs_val = '0;
    if (rs_idx != 4'd0)
      rs_val = (wb_we && wb_reg == rs_idx) ? wb_data : rf_q[rs_idx];
    rt_val = '0;
    if (rt_idx != 4'd0)
      rt_val = (wb_we && wb_reg == rt_idx) ? wb_data : rf_q[rt_idx];

    fwd_hit = FWD_EN && exm_wr_en && !exm_is_load && exm_wr_reg == rs_idx && rs_idx != 4'd0;
    rs_op   = fwd_hit ? exm_result : rs_val;

    unique case (op)
      OP_LW, OP_SW: imm = DATA_W'({instr_in[3:0], 1'b0});
      OP_LLB:       imm = DATA_W'(instr_in[7:0]);
      OP_LHB:       imm = DATA_W'({instr_in[7:0], 8'h00});
      default:      imm = DATA_W'(instr_in[3:0]);
    endcase

    // flags_q = {N, Z, V}
    unique case (instr_in[11:9])
      3'b000:  cond_true = !flags_q[1];
      3'b001:  cond_true = flags_q[1];
      3'b010:  cond_true = !flags_q[1] && !flags_q[2];
      3'b011:  cond_true = flags_q[2];
      3'b100:  cond_true = flags_q[1] || (!flags_q[1] && !flags_q[2]);
      3'b101:  cond_true = flags_q[2] || flags_q[1];
      3'b110:  cond_true = flags_q[0];
      default: cond_true = 1'b1;
    endcase

    pc_plus2 = pc_in + PC_W'(2);
    b_target = pc_plus2 + (PC_W'({{(PC_W-9){instr_in[8]}}, instr_in[8:0]}) << 1);

    haz_load    = idex_q.valid && idex_q.mem_rd && idex_q.rd != 4'd0 &&
                  ((uses_rs && idex_q.rd == rs_idx) || (uses_rt && idex_q.rd == rt_idx));
    haz_br_idex = is_br && idex_q.valid && idex_q.wr_en && idex_q.rd == rs_idx && rs_idx != 4'd0;
    haz_br_exm  = is_br && exm_wr_en && exm_wr_reg == rs_idx && rs_idx != 4'd0 &&
                  (exm_is_load || !FWD_EN);
    haz_flag    = (is_b || is_br) && instr_in[11:9] != 3'b111 && idex_q.valid && (|idex_q.flag_we);

    stall     = valid_in && !halted_q && (haz_load || haz_br_idex || haz_br_exm || haz_flag);
    flush     = valid_in && !stall && !halted_q && (is_b || is_br) && cond_true;
    branch_pc = pc_plus2;
    if (flush)
      branch_pc = is_br ? PC_W'(rs_op) : b_target;

    halted_d = halted_q || (valid_in && !stall && op == OP_HLT);

    rf_d = rf_q;
    if (wb_we && wb_reg != 4'd0)
      rf_d[wb_reg] = wb_data;
    for (int unsigned i = 0; i < 3; i++)
      flags_d[i] = flag_we[i] ? flags_in[i] : flags_q[i];

    idex_d = '0;
    if (valid_in && !stall && !halted_q) begin
      idex_d.valid   = 1'b1;
      idex_d.instr   = instr_in;
      idex_d.pc      = pc_in;
      idex_d.rs_data = rs_op;
      idex_d.rt_data = rt_val;
      idex_d.imm     = imm;
      idex_d.rd      = instr_in[11:8];
      idex_d.wr_en   = (instr_in[15:12] <= 4'h8) || op == OP_LLB || op == OP_LHB || op == OP_PCS;
      idex_d.mem_rd  = (op == OP_LW);
      idex_d.mem_wr  = (op == OP_SW);
      unique case (op)
        OP_ADD, OP_SUB:                 idex_d.flag_we = 3'b111;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: idex_d.flag_we = 3'b010;
        default:                        idex_d.flag_we = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++)
        rf_q[i] <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
      idex_q   <= '0;
    end else begin
      rf_q     <= rf_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
      idex_q   <= idex_d;
    end
  end

  assign halted            = halted_q;
  assign idex.idex_valid   = idex_q.valid;
  assign idex.idex_instr   = idex_q.instr;
  assign idex.idex_pc      = idex_q.pc;
  assign idex.idex_rs_data = idex_q.rs_data;
  assign idex.idex_rt_data = idex_q.rt_data;
  assign idex.idex_imm     = idex_q.imm;
  assign idex.idex_rd      = idex_q.rd;
  assign idex.idex_wr_en   = idex_q.wr_en;
  assign idex.idex_mem_rd  = idex_q.mem_rd;
  assign idex.idex_mem_wr  = idex_q.mem_wr;
  assign idex.idex_flag_we = idex_q.flag_we;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench: two decode stages (forwarding on/off) driven from shared inputs.
module tb_pipelined_decode_stage;

  logic        clk = 1'b0;
  logic        rst, valid_in;
  logic [15:0] instr_in, pc_in;
  logic        wb_we;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic [2:0]  flag_we, flags_in;
  logic        exm_wr_en, exm_is_load;
  logic [3:0]  exm_wr_reg;
  logic [15:0] exm_result;

  logic        stall_f, flush_f, halted_f, stall_n, flush_n, halted_n;
  logic [15:0] bpc_f, bpc_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_decode_stage_if #(.DATA_W(16), .PC_W(16)) ifx_f ();
  pipelined_decode_stage_if #(.DATA_W(16), .PC_W(16)) ifx_n ();

  pipelined_decode_stage #(.DATA_W(16), .PC_W(16), .FWD_EN(1'b1)) dut_f (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .flag_we(flag_we), .flags_in(flags_in),
    .exm_wr_en(exm_wr_en), .exm_wr_reg(exm_wr_reg), .exm_is_load(exm_is_load),
    .exm_result(exm_result), .stall(stall_f), .flush(flush_f), .branch_pc(bpc_f),
    .halted(halted_f), .idex(ifx_f)
  );

  pipelined_decode_stage #(.DATA_W(16), .PC_W(16), .FWD_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .flag_we(flag_we), .flags_in(flags_in),
    .exm_wr_en(exm_wr_en), .exm_wr_reg(exm_wr_reg), .exm_is_load(exm_is_load),
    .exm_result(exm_result), .stall(stall_n), .flush(flush_n), .branch_pc(bpc_n),
    .halted(halted_n), .idex(ifx_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; instr_in = '0; pc_in = '0;
    wb_we = 1'b1; wb_reg = 4'd2; wb_data = 16'hBEEF;
    flag_we = 3'b111; flags_in = 3'b111;
    exm_wr_en = 1'b0; exm_wr_reg = '0; exm_is_load = 1'b0; exm_result = '0;
    tick();
    tick();
    chk("rst_idex_valid", ifx_f.idex_valid, 1'b0);
    chk("rst_idex_instr", ifx_f.idex_instr, 16'h0000);
    chk("rst_halted", halted_f, 1'b0);
    chk("rst_stall", stall_f, 1'b0);

    // WB R3=0x1234 while decoding ADD R4,R3,R0
    rst = 1'b0; flag_we = 3'b000; flags_in = 3'b000;
    wb_reg = 4'd3; wb_data = 16'h1234;
    valid_in = 1'b1; instr_in = 16'h0430; pc_in = 16'h0010;
    #1;
    chk("add_stall", stall_f, 1'b0);
    chk("add_flush", flush_f, 1'b0);
    chk("add_bpc", bpc_f, 16'h0012);
    tick();
    chk("byp_valid", ifx_f.idex_valid, 1'b1);
    chk("byp_rs_data", ifx_f.idex_rs_data, 16'h1234);
    chk("byp_rt_data", ifx_f.idex_rt_data, 16'h0000);
    chk("byp_rd", ifx_f.idex_rd, 4'd4);
    chk("byp_flag_we", ifx_f.idex_flag_we, 3'b111);
    chk("byp_pc", ifx_f.idex_pc, 16'h0010);

    // ADD R1,R2,R3: R2 write was masked by reset; write R1=0x0011
    wb_reg = 4'd1; wb_data = 16'h0011;
    instr_in = 16'h0123; pc_in = 16'h0012;
    tick();
    chk("rf_rs_r2", ifx_f.idex_rs_data, 16'h0000);
    chk("rf_rt_r3", ifx_f.idex_rt_data, 16'h1234);

    // LW R5, [R1 + 2]
    wb_we = 1'b0;
    instr_in = 16'h8511; pc_in = 16'h0014;
    tick();
    chk("lw_mem_rd", ifx_f.idex_mem_rd, 1'b1);
    chk("lw_imm", ifx_f.idex_imm, 16'h0002);
    chk("lw_wr_en", ifx_f.idex_wr_en, 1'b1);
    chk("lw_rs_data", ifx_f.idex_rs_data, 16'h0011);
    chk("lw_flag_we", ifx_f.idex_flag_we, 3'b000);

    // ADD R6,R5,R1 behind the load
    instr_in = 16'h0651; pc_in = 16'h0016;
    #1;
    chk("lu_stall", stall_f, 1'b1);
    chk("lu_flush", flush_f, 1'b0);
    tick();
    chk("lu_bubble_valid", ifx_f.idex_valid, 1'b0);
    chk("lu_bubble_wr_en", ifx_f.idex_wr_en, 1'b0);
    chk("lu_bubble_mem_rd", ifx_f.idex_mem_rd, 1'b0);
    chk("lu_stall_done", stall_f, 1'b0);
    tick();
    chk("lu_issue_valid", ifx_f.idex_valid, 1'b1);
    chk("lu_issue_instr", ifx_f.idex_instr, 16'h0651);

    // SUB R7,R1,R1, then B cond 001 offset -2 at 0x0040
    instr_in = 16'h1711; pc_in = 16'h0018;
    tick();
    flag_we = 3'b111; flags_in = 3'b010;
    instr_in = 16'hC3FE; pc_in = 16'h0040;
    #1;
    chk("flag_haz_stall", stall_f, 1'b1);
    chk("flag_haz_flush", flush_f, 1'b0);
    tick();
    flag_we = 3'b000; flags_in = 3'b000;
    #1;
    chk("b_stall", stall_f, 1'b0);
    chk("b_flush", flush_f, 1'b1);
    chk("b_target", bpc_f, 16'h003E);
    tick();
    chk("b_idex_valid", ifx_f.idex_valid, 1'b1);
    chk("b_idex_wr_en", ifx_f.idex_wr_en, 1'b0);

    // B cond 000 (Z=0) not taken with Z=1
    instr_in = 16'hC1FE;
    #1;
    chk("bnt_flush", flush_f, 1'b0);
    chk("bnt_bpc", bpc_f, 16'h0042);
    tick();

    // BR R7 cond 111 with EX/MEM writing R7 (non-load)
    instr_in = 16'hDE70; pc_in = 16'h0080;
    exm_wr_en = 1'b1; exm_wr_reg = 4'd7; exm_is_load = 1'b0; exm_result = 16'h0200;
    #1;
    chk("br_fwd_stall", stall_f, 1'b0);
    chk("br_fwd_flush", flush_f, 1'b1);
    chk("br_fwd_target", bpc_f, 16'h0200);
    chk("br_nofwd_stall", stall_n, 1'b1);
    chk("br_nofwd_flush", flush_n, 1'b0);
    tick();
    exm_wr_en = 1'b0; exm_wr_reg = '0; exm_result = '0;
    wb_we = 1'b1; wb_reg = 4'd7; wb_data = 16'h0200;
    #1;
    chk("br_nofwd_stall2", stall_n, 1'b0);
    chk("br_nofwd_flush2", flush_n, 1'b1);
    chk("br_nofwd_target", bpc_n, 16'h0200);
    tick();
    wb_we = 1'b0;

    // HLT, then ADD and an always-taken B while halted
    instr_in = 16'hF000; pc_in = 16'h0090;
    #1;
    chk("hlt_stall", stall_f, 1'b0);
    tick();
    chk("hlt_halted", halted_f, 1'b1);
    chk("hlt_idex_valid", ifx_f.idex_valid, 1'b1);
    instr_in = 16'h0123; pc_in = 16'h0092;
    #1;
    chk("halt_stall", stall_f, 1'b0);
    tick();
    chk("halt_bubble", ifx_f.idex_valid, 1'b0);
    chk("halt_sticky", halted_f, 1'b1);
    instr_in = 16'hCE00;
    #1;
    chk("halt_no_flush", flush_f, 1'b0);

    // Reset clears halted, ID/EX and the register file
    rst = 1'b1;
    tick();
    chk("rst2_halted", halted_f, 1'b0);
    chk("rst2_idex_valid", ifx_f.idex_valid, 1'b0);
    chk("rst2_idex_instr", ifx_f.idex_instr, 16'h0000);
    chk("rst2_idex_pc", ifx_f.idex_pc, 16'h0000);
    chk("rst2_idex_rs", ifx_f.idex_rs_data, 16'h0000);
    rst = 1'b0;
    instr_in = 16'h0130; pc_in = 16'h0000;
    tick();
    chk("rst2_r3_cleared", ifx_f.idex_rs_data, 16'h0000);
    chk("rst2_issue", ifx_f.idex_valid, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
